// File: rtl/block_renderer.sv
// Block renderer: turns block-position updates and game-status changes into
// one-pixel-per-clock writes (full-screen fill, block erase, block draw).
module block_renderer #(
  parameter int         BLOCK_W      = 20,
  parameter int         BLOCK_H      = 4,
  parameter int         SCREEN_W     = 160,
  parameter int         SCREEN_H     = 120,
  parameter logic [2:0] BLOCK_COLOUR = 3'b011
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sync,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [1:0] game_status,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       missed_sync
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_ERASE, S_DRAW} state_t;

  state_t     state_reg, state_next;
  logic [8:0] col_reg, row_reg;
  logic [7:0] lx_reg, last_x_reg;
  logic [6:0] ly_reg, last_y_reg;
  logic       last_valid_reg;
  logic [1:0] prev_status_reg;
  logic       pending_fill_reg;
  logic [2:0] pending_colour_reg, fill_colour_reg;
  logic [7:0] vga_x_reg;
  logic [6:0] vga_y_reg;
  logic [2:0] vga_colour_reg;
  logic       vga_plot_reg, busy_reg, missed_sync_reg;

  logic       status_chg, sync_ok, last_pixel, in_bounds;
  logic [8:0] span_w, span_h, org_x, org_y, px, py;
  logic [2:0] pix_colour, status_colour;

  // Scan geometry and colour of the operation in progress
  always_comb begin
    status_chg = (game_status != prev_status_reg);
    sync_ok    = sync && (state_reg == S_IDLE) && !pending_fill_reg &&
                 (game_status == 2'd1) && !status_chg;
    span_w     = 9'(BLOCK_W);
    span_h     = 9'(BLOCK_H);
    org_x      = 9'd0;
    org_y      = 9'd0;
    pix_colour = 3'b000;
    case (state_reg)
      S_FILL: begin
        span_w     = 9'(SCREEN_W);
        span_h     = 9'(SCREEN_H);
        pix_colour = fill_colour_reg;
      end
      S_ERASE: begin
        org_x = {1'b0, last_x_reg};
        org_y = {2'b00, last_y_reg};
      end
      S_DRAW: begin
        org_x      = {1'b0, lx_reg};
        org_y      = {2'b00, ly_reg};
        pix_colour = BLOCK_COLOUR;
      end
      default: ;
    endcase
    last_pixel = (col_reg == span_w - 9'd1) && (row_reg == span_h - 9'd1);
    px         = org_x + col_reg;
    py         = org_y + row_reg;
    in_bounds  = (px < 9'(SCREEN_W)) && (py < 9'(SCREEN_H));
  end

  always_comb begin
    case (game_status)
      2'd2:    status_colour = 3'b010;
      2'd3:    status_colour = 3'b100;
      default: status_colour = 3'b000;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (pending_fill_reg)
          state_next = S_FILL;
        else if (sync_ok)
          state_next = (last_valid_reg && last_y_reg == y && last_x_reg != x) ? S_ERASE : S_DRAW;
      end
      S_FILL:  if (last_pixel) state_next = S_IDLE;
      S_ERASE: if (last_pixel) state_next = S_DRAW;
      S_DRAW:  if (last_pixel) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  // Counters restart on every state change so each scan begins at its origin
  always_ff @(posedge clk) begin
    if (reset || state_next != state_reg) begin
      col_reg <= 9'd0;
      row_reg <= 9'd0;
    end else if (state_reg != S_IDLE) begin
      if (col_reg == span_w - 9'd1) begin
        col_reg <= 9'd0;
        row_reg <= row_reg + 9'd1;
      end else begin
        col_reg <= col_reg + 9'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lx_reg             <= 8'd0;
      ly_reg             <= 7'd0;
      last_x_reg         <= 8'd0;
      last_y_reg         <= 7'd0;
      last_valid_reg     <= 1'b0;
      prev_status_reg    <= 2'd0;
      pending_fill_reg   <= 1'b1;
      pending_colour_reg <= 3'b000;
      fill_colour_reg    <= 3'b000;
      missed_sync_reg    <= 1'b0;
    end else begin
      prev_status_reg <= game_status;
      // A fresh status change wins over the fill being launched this cycle
      if (status_chg) begin
        pending_fill_reg   <= 1'b1;
        pending_colour_reg <= status_colour;
      end else if (state_reg == S_IDLE && pending_fill_reg) begin
        pending_fill_reg <= 1'b0;
      end
      if (state_reg == S_IDLE && pending_fill_reg)
        fill_colour_reg <= pending_colour_reg;
      if (sync && !sync_ok)
        missed_sync_reg <= 1'b1;
      if (sync_ok) begin
        lx_reg <= x;
        ly_reg <= y;
      end
      if (state_reg == S_FILL && last_pixel)
        last_valid_reg <= 1'b0;
      if (state_reg == S_DRAW && last_pixel) begin
        last_x_reg     <= lx_reg;
        last_y_reg     <= ly_reg;
        last_valid_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vga_x_reg      <= 8'd0;
      vga_y_reg      <= 7'd0;
      vga_colour_reg <= 3'b000;
      vga_plot_reg   <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      vga_x_reg      <= px[7:0];
      vga_y_reg      <= py[6:0];
      vga_colour_reg <= pix_colour;
      vga_plot_reg   <= (state_reg != S_IDLE) && in_bounds;
      busy_reg       <= (state_reg != S_IDLE);
    end
  end

  assign vga_x       = vga_x_reg;
  assign vga_y       = vga_y_reg;
  assign vga_colour  = vga_colour_reg;
  assign vga_plot    = vga_plot_reg;
  assign busy        = busy_reg;
  assign missed_sync = missed_sync_reg;

endmodule

// File: tb/tb_block_renderer.sv
// Bench for block_renderer: screen-level model of expected plots and busy
// run lengths, directed scenarios plus randomized block moves.
module tb_block_renderer;
  localparam int BW = 20, BH = 4, SW = 160, SH = 120;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sync = 1'b0;
  logic [7:0] x = 8'd0;
  logic [6:0] y = 7'd0;
  logic [1:0] game_status = 2'd0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot, busy, missed_sync;

  always #5 clk = ~clk;

  block_renderer dut (
    .clk(clk), .reset(reset), .sync(sync), .x(x), .y(y),
    .game_status(game_status), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy),
    .missed_sync(missed_sync)
  );

  typedef struct {int px; int py; int c;} pix_t;
  pix_t exp_q[$];
  int   exp_runs[$];
  int   checks = 0, errors = 0;
  int   m_last_x = 0, m_last_y = 0;
  bit   m_last_valid = 0;
  int   run_len = 0, run_plots = 0, run_fx = 0, run_fy = 0, run_fc = 0;
  int   last_run_plots = 0, last_run_fx = 0, last_run_fy = 0, last_run_fc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Every plot must be the next expected pixel; every busy run must match
  always @(negedge clk) begin
    pix_t e;
    if (reset) begin
      run_len   = 0;
      run_plots = 0;
    end else begin
      if (vga_plot === 1'b1) begin
        chk("busy_during_plot", {31'd0, busy}, 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_plot: got (%0d,%0d) colour %0d, no plot expected",
                   vga_x, vga_y, vga_colour);
        end else begin
          e = exp_q.pop_front();
          chk("pixel", {14'd0, vga_x, vga_y, vga_colour},
              {14'd0, 8'(e.px), 7'(e.py), 3'(e.c)});
        end
        if (run_plots == 0) begin
          run_fx = int'(vga_x);
          run_fy = int'(vga_y);
          run_fc = int'(vga_colour);
        end
        run_plots++;
      end
      if (busy === 1'b1) begin
        run_len++;
      end else if (run_len > 0) begin
        if (exp_runs.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL busy_run: got %0d cycles, none expected", run_len);
        end else begin
          chk("busy_run", run_len, exp_runs.pop_front());
        end
        last_run_plots = run_plots;
        last_run_fx    = run_fx;
        last_run_fy    = run_fy;
        last_run_fc    = run_fc;
        run_len        = 0;
        run_plots      = 0;
      end
    end
  end

  task automatic push_rect(input int ox, input int oy, input int c);
    pix_t p;
    for (int r = 0; r < BH; r++)
      for (int k = 0; k < BW; k++)
        if (ox + k < SW && oy + r < SH) begin
          p.px = ox + k;
          p.py = oy + r;
          p.c  = c;
          exp_q.push_back(p);
        end
  endtask

  task automatic push_fill(input int c);
    pix_t p;
    for (int r = 0; r < SH; r++)
      for (int k = 0; k < SW; k++) begin
        p.px = k;
        p.py = r;
        p.c  = c;
        exp_q.push_back(p);
      end
    exp_runs.push_back(SW * SH);
    m_last_valid = 0;
  endtask

  task automatic do_sync(input int sx, input int sy);
    if (m_last_valid && m_last_y == sy && m_last_x != sx) begin
      push_rect(m_last_x, m_last_y, 0);
      push_rect(sx, sy, 3);
      exp_runs.push_back(2 * BW * BH);
    end else begin
      push_rect(sx, sy, 3);
      exp_runs.push_back(BW * BH);
    end
    m_last_x     = sx;
    m_last_y     = sy;
    m_last_valid = 1;
    @(posedge clk);
    #1;
    x    = 8'(sx);
    y    = 7'(sy);
    sync = 1'b1;
    @(posedge clk);
    #1;
    sync = 1'b0;
  endtask

  task automatic set_status(input int s);
    @(posedge clk);
    #1;
    game_status = 2'(s);
    push_fill(s == 2 ? 2 : (s == 3 ? 4 : 0));
  endtask

  task automatic wait_op(input string name);
    int n;
    n = 0;
    while (busy !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_start: busy got %b, required 1 within 20 cycles", name, busy);
      return;
    end
    n = 0;
    while (busy !== 1'b0 && n < 25000) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL %s_end: busy got %b, required 0 within 25000 cycles", name, busy);
    end
    @(negedge clk);
  endtask

  initial begin
    int sx, sy;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_vga_x", vga_x, 0);
    chk("rst_vga_y", vga_y, 0);
    chk("rst_colour", vga_colour, 0);
    chk("rst_plot", vga_plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_missed", missed_sync, 0);

    // Power-up clear, aborted by a reset, then rerun to completion
    push_fill(0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (100) @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    exp_runs.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_plot", vga_plot, 0);
    push_fill(0);
    @(posedge clk);
    #1 reset = 1'b0;
    wait_op("powerup_fill");
    chk("powerup_plots", last_run_plots, 19200);
    chk("powerup_colour", last_run_fc, 0);

    set_status(1);
    wait_op("playing_fill");
    chk("playing_fill_plots", last_run_plots, 19200);

    do_sync(40, 100);
    wait_op("first_draw");
    chk("first_draw_plots", last_run_plots, 80);
    chk("first_draw_x", last_run_fx, 40);
    chk("first_draw_y", last_run_fy, 100);
    chk("first_draw_colour", last_run_fc, 3);

    do_sync(42, 100);
    wait_op("same_row");
    chk("same_row_plots", last_run_plots, 160);
    chk("same_row_erase_x", last_run_fx, 40);
    chk("same_row_erase_colour", last_run_fc, 0);

    do_sync(42, 96);
    wait_op("new_row");
    chk("new_row_plots", last_run_plots, 80);
    chk("new_row_x", last_run_fx, 42);
    chk("new_row_y", last_run_fy, 96);

    do_sync(150, 60);
    wait_op("clip_x");
    chk("clip_x_plots", last_run_plots, 40);
    chk("clip_x_first", last_run_fx, 150);

    do_sync(10, 118);
    wait_op("clip_y");
    chk("clip_y_plots", last_run_plots, 40);

    for (int i = 0; i < 24; i++) begin
      sx = int'($urandom_range(0, 255));
      sy = ($urandom_range(0, 1) == 1) ? m_last_y : int'($urandom_range(0, 127));
      if ($urandom_range(0, 5) == 0) sx = m_last_x;
      do_sync(sx, sy);
      wait_op("random_move");
      $display("move %0d: x=%0d y=%0d plots=%0d", i, sx, sy, last_run_plots);
    end
    chk("missed_still_clear", missed_sync, 0);

    // Dropped sync mid-draw, then two status changes: the latest colour wins
    do_sync(70, (m_last_y + 7) % 128);
    repeat (5) @(posedge clk);
    #1;
    x    = 8'd5;
    y    = 7'd5;
    sync = 1'b1;
    @(posedge clk);
    #1 sync = 1'b0;
    @(negedge clk);
    chk("missed_set", missed_sync, 1);
    @(posedge clk);
    #1 game_status = 2'd2;
    repeat (3) @(posedge clk);
    #1 game_status = 2'd3;
    push_fill(4);
    wait_op("contended_draw");
    wait_op("lost_fill");
    chk("lost_fill_plots", last_run_plots, 19200);
    chk("lost_fill_colour", last_run_fc, 4);
    chk("missed_sticky", missed_sync, 1);

    repeat (10) @(negedge clk);
    chk("leftover_pixels", exp_q.size(), 0);
    chk("leftover_runs", exp_runs.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
